// File: rtl/core_pkg.sv
// Shared types for the core memory subsystem: access sizes and arbiter FSM encoding.
package core_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StResp = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        OwnFetch = 1'b0,
        OwnData  = 1'b1
    } mem_owner_e;

    localparam int unsigned StreakW = 4;

endpackage

// File: rtl/core_mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one downstream memory port,
// one outstanding transaction at a time, with a fetch starvation guard.
module core_mem_arbiter
    import core_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic          i_if_req,
    output logic          o_if_ready,
    input  logic [AW-1:0] i_if_addr,
    input  logic          i_if_flush,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,

    input  logic          i_d_req,
    output logic          o_d_ready,
    input  logic [AW-1:0] i_d_addr,
    input  logic          i_d_we,
    input  logic [DW-1:0] i_d_wdata,
    input  logic [1:0]    i_d_size,
    output logic          o_d_rvalid,
    output logic [DW-1:0] o_d_rdata,

    output logic          o_mem_valid,
    input  logic          i_mem_ready,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    output logic [1:0]    o_mem_size,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata,

    output logic          o_busy
);

    localparam logic [StreakW-1:0] MaxStreak = StreakW'(MAX_D_STREAK);

    mem_arb_state_e     state_q, state_d;
    mem_owner_e         owner_q, owner_d;
    logic [StreakW-1:0] streak_q, streak_d;
    logic               kill_q, kill_d;

    logic [AW-1:0]      addr_q, addr_d;
    logic               we_q, we_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    mem_size_e          size_q, size_d;

    logic               fetch_ok;
    logic               streak_full;
    logic               grant_fetch;
    logic               grant_data;
    logic               flush_hit;

    // Data normally wins; fetch only wins once data has hogged the port
    // MAX_D_STREAK times, or when data is not asking. Gated by reset so no
    // ready can pulse while the block is held in reset.
    always_comb begin
        fetch_ok    = i_if_req & ~i_if_flush;
        streak_full = (streak_q == MaxStreak);
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state_q == StIdle && i_rst_n) begin
            if (fetch_ok && (streak_full || !i_d_req)) begin
                grant_fetch = 1'b1;
            end else if (i_d_req) begin
                grant_data = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        kill_d      = kill_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        o_mem_valid = 1'b0;
        o_if_rvalid = 1'b0;
        o_d_rvalid  = 1'b0;
        flush_hit   = i_if_flush && (owner_q == OwnFetch);

        unique case (state_q)
            StIdle: begin
                kill_d = 1'b0;
                if (!i_if_req) begin
                    streak_d = '0;
                end
                if (grant_fetch) begin
                    owner_d  = OwnFetch;
                    addr_d   = i_if_addr;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    size_d   = SIZE_WORD;
                    streak_d = '0;
                    state_d  = StReq;
                end else if (grant_data) begin
                    owner_d = OwnData;
                    addr_d  = i_d_addr;
                    we_d    = i_d_we;
                    wdata_d = i_d_wdata;
                    size_d  = mem_size_e'(i_d_size);
                    if (i_if_req && !streak_full) begin
                        streak_d = streak_q + 1'b1;
                    end
                    state_d = StReq;
                end
            end
            StReq: begin
                // Request stays up even if the fetch is killed; the response is dropped later.
                o_mem_valid = 1'b1;
                if (flush_hit) begin
                    kill_d = 1'b1;
                end
                if (i_mem_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (flush_hit) begin
                    kill_d = 1'b1;
                end
                if (i_mem_rvalid) begin
                    o_if_rvalid = (owner_q == OwnFetch) && !kill_q && !i_if_flush;
                    o_d_rvalid  = (owner_q == OwnData);
                    kill_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            owner_q  <= OwnFetch;
            streak_q <= '0;
            kill_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            size_q   <= SIZE_BYTE;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            kill_q   <= kill_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
        end
    end

    assign o_if_ready  = grant_fetch;
    assign o_d_ready   = grant_data;
    assign o_busy      = (state_q != StIdle);
    assign o_mem_addr  = addr_q;
    assign o_mem_we    = we_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_size  = size_q;
    assign o_if_rdata  = i_mem_rdata;
    assign o_d_rdata   = i_mem_rdata;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: a small downstream memory model, queued
// request expectations and queued response expectations.
module tb_core_mem_arbiter;
    import core_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_if_req = 1'b0, i_if_flush = 1'b0, i_d_req = 1'b0, i_d_we = 1'b0;
    logic [31:0] i_if_addr = '0, i_d_addr = '0, i_d_wdata = '0, i_mem_rdata = '0;
    logic [1:0]  i_d_size = '0;
    logic        i_mem_ready = 1'b0, i_mem_rvalid = 1'b0;
    logic        o_if_ready, o_if_rvalid, o_d_ready, o_d_rvalid, o_mem_valid, o_mem_we, o_busy;
    logic [31:0] o_if_rdata, o_d_rdata, o_mem_addr, o_mem_wdata;
    logic [1:0]  o_mem_size;

    core_mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_if_req(i_if_req), .o_if_ready(o_if_ready), .i_if_addr(i_if_addr),
        .i_if_flush(i_if_flush), .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .o_d_ready(o_d_ready), .i_d_addr(i_d_addr), .i_d_we(i_d_we),
        .i_d_wdata(i_d_wdata), .i_d_size(i_d_size), .o_d_rvalid(o_d_rvalid),
        .o_d_rdata(o_d_rdata), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .o_mem_size(o_mem_size), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_busy(o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_req_t;

    typedef struct packed {
        logic        is_data;
        logic [31:0] data;
    } rsp_t;

    mem_req_t    d_q[$];
    logic [31:0] f_q[$];
    mem_req_t    exp_mem_q[$];
    rsp_t        exp_rsp_q[$];
    logic        grant_log[$];

    int          n_checks = 0;
    int          n_pass = 0;
    int          mem_wait = 0;
    int          mem_wait_cnt = 0;
    logic        mem_rsp_pending = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    int          flush_mode = 0;  // 0 none, 1 first RESP cycle, 2 first REQ cycle
    logic        flush_now = 1'b0;
    int          busy_cnt = 0;
    int          first_grant = -1;

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic push_fetch(input logic [31:0] addr, input bit killed);
        mem_req_t m;
        rsp_t     r;
        m = '{addr: addr, we: 1'b0, wdata: 32'h0, size: SIZE_WORD};
        f_q.push_back(addr);
        exp_mem_q.push_back(m);
        if (!killed) begin
            r = '{is_data: 1'b0, data: mem_fn(addr)};
            exp_rsp_q.push_back(r);
        end
    endtask

    task automatic push_data(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [1:0] size);
        mem_req_t m;
        rsp_t     r;
        m = '{addr: addr, we: we, wdata: wdata, size: size};
        r = '{is_data: 1'b1, data: mem_fn(addr)};
        d_q.push_back(m);
        exp_mem_q.push_back(m);
        exp_rsp_q.push_back(r);
    endtask

    task automatic drive_cycle();
        i_if_req   = (f_q.size() > 0);
        i_if_addr  = (f_q.size() > 0) ? f_q[0] : 32'h0;
        i_d_req    = (d_q.size() > 0);
        i_d_addr   = (d_q.size() > 0) ? d_q[0].addr : 32'h0;
        i_d_we     = (d_q.size() > 0) ? d_q[0].we : 1'b0;
        i_d_wdata  = (d_q.size() > 0) ? d_q[0].wdata : 32'h0;
        i_d_size   = (d_q.size() > 0) ? d_q[0].size : 2'd0;
        i_if_flush = 1'b0;
        flush_now  = 1'b0;
        if ((flush_mode == 1 && o_busy && !o_mem_valid) || (flush_mode == 2 && o_mem_valid)) begin
            i_if_flush = 1'b1;
            flush_now  = 1'b1;
            flush_mode = 0;
        end
        i_mem_rvalid = mem_rsp_pending;
        i_mem_rdata  = mem_rsp_pending ? mem_rsp_data : 32'h0;
        i_mem_ready  = o_mem_valid && (mem_wait_cnt >= mem_wait);
    endtask

    task automatic sample_cycle(input int cyc);
        mem_req_t e;
        rsp_t     r;
        if (o_busy) busy_cnt++;
        if (flush_now) check_eq("flush_if_rvalid", 32'(o_if_rvalid), 32'd0);
        if (o_if_ready || o_d_ready) begin
            check_eq("one_ready", 32'(o_if_ready & o_d_ready), 32'd0);
            if (first_grant < 0) first_grant = cyc;
        end
        if (o_if_ready) begin
            grant_log.push_back(1'b0);
            if (f_q.size() > 0) void'(f_q.pop_front());
        end
        if (o_d_ready) begin
            grant_log.push_back(1'b1);
            if (d_q.size() > 0) void'(d_q.pop_front());
        end
        if (i_mem_rvalid) mem_rsp_pending = 1'b0;
        if (o_mem_valid) begin
            if (exp_mem_q.size() == 0) begin
                check_eq("mem_unexpected", 32'(o_mem_valid), 32'd0);
            end else begin
                e = exp_mem_q[0];
                check_eq("mem_addr", o_mem_addr, e.addr);
                check_eq("mem_we", 32'(o_mem_we), 32'(e.we));
                check_eq("mem_size", 32'(o_mem_size), 32'(e.size));
                if (e.we) check_eq("mem_wdata", o_mem_wdata, e.wdata);
            end
            if (i_mem_ready) begin
                if (exp_mem_q.size() > 0) void'(exp_mem_q.pop_front());
                mem_rsp_pending = 1'b1;
                mem_rsp_data    = mem_fn(o_mem_addr);
                mem_wait_cnt    = 0;
            end else begin
                mem_wait_cnt++;
            end
        end else begin
            mem_wait_cnt = 0;
        end
        if (o_if_rvalid || o_d_rvalid) begin
            if (exp_rsp_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'({o_if_rvalid, o_d_rvalid}), 32'd0);
            end else begin
                r = exp_rsp_q.pop_front();
                check_eq("rsp_port", 32'({o_if_rvalid, o_d_rvalid}), r.is_data ? 32'd1 : 32'd2);
                check_eq("rsp_data", r.is_data ? o_d_rdata : o_if_rdata, r.data);
            end
        end
    endtask

    // Runs from just after a rising edge; returns just after the next rising edge
    // once idle, or mid-cycle at the first REQ cycle when stop_on_valid is set.
    task automatic run_traffic(input int max_cycles, input bit stop_on_valid);
        int cyc = 0;
        bit done = 1'b0;
        first_grant = -1;
        busy_cnt = 0;
        grant_log.delete();
        while (!done) begin
            drive_cycle();
            #4;
            sample_cycle(cyc);
            cyc++;
            if (stop_on_valid && o_mem_valid) begin
                done = 1'b1;
            end else if (!stop_on_valid && f_q.size() == 0 && d_q.size() == 0 && !o_busy &&
                         !mem_rsp_pending && !o_if_ready && !o_d_ready) begin
                done = 1'b1;
            end else if (cyc >= max_cycles) begin
                check_eq("timeout_outstanding",
                         32'(f_q.size() + d_q.size() + int'(o_busy) + int'(mem_rsp_pending)),
                         32'd0);
                done = 1'b1;
            end
            if (!done || !stop_on_valid) begin
                @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic end_test(input string tag);
        check_eq({tag, "_mem_left"}, 32'(exp_mem_q.size()), 32'd0);
        check_eq({tag, "_rsp_left"}, 32'(exp_rsp_q.size()), 32'd0);
    endtask

    initial begin
        logic exp_order [6];
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state, with both requesters pushing.
        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        #12;
        check_eq("rst_if_ready", 32'(o_if_ready), 32'd0);
        check_eq("rst_d_ready", 32'(o_d_ready), 32'd0);
        check_eq("rst_mem_valid", 32'(o_mem_valid), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_mem_addr", o_mem_addr, 32'd0);
        check_eq("rst_mem_we", 32'(o_mem_we), 32'd0);
        i_if_req = 1'b0;
        i_d_req  = 1'b0;
        #10 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Single fetch, downstream ready after two wait cycles.
        mem_wait = 2;
        push_fetch(32'h100, 1'b0);
        run_traffic(40, 1'b0);
        check_eq("fetch_busy_cycles", 32'(busy_cnt), 32'd4);
        check_eq("fetch_first_grant", 32'(first_grant), 32'd0);
        end_test("fetch");

        // Both ports busy: data streak limit lets fetch in after four data grants.
        mem_wait = 0;
        push_data(32'h3000, 1'b0, 32'h0, SIZE_WORD);
        push_data(32'h3004, 1'b0, 32'h0, SIZE_WORD);
        push_data(32'h3008, 1'b0, 32'h0, SIZE_WORD);
        push_data(32'h300C, 1'b0, 32'h0, SIZE_WORD);
        push_fetch(32'h400, 1'b0);
        push_data(32'h3010, 1'b0, 32'h0, SIZE_WORD);
        run_traffic(100, 1'b0);
        check_eq("order_len", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check_eq($sformatf("order_%0d", i), 32'(grant_log[i]),
                                               32'(exp_order[i]));
        end
        end_test("order");

        // Half-word store held through three wait cycles.
        mem_wait = 3;
        push_data(32'h2000, 1'b1, 32'h1234_5678, SIZE_HALF);
        run_traffic(40, 1'b0);
        check_eq("store_busy_cycles", 32'(busy_cnt), 32'd5);
        end_test("store");

        // Flush coinciding with the fetch response; then a normal data load.
        mem_wait = 0;
        push_fetch(32'h500, 1'b1);
        flush_mode = 1;
        run_traffic(40, 1'b0);
        push_data(32'h600, 1'b0, 32'h0, SIZE_WORD);
        run_traffic(40, 1'b0);
        check_eq("post_flush_grant", 32'(first_grant), 32'd0);
        end_test("flush_resp");

        // Flush while the fetch is still waiting for ready; kill must not leak.
        mem_wait = 2;
        push_fetch(32'h540, 1'b1);
        flush_mode = 2;
        run_traffic(40, 1'b0);
        push_fetch(32'h580, 1'b0);
        run_traffic(40, 1'b0);
        end_test("flush_req");

        // Reset in the middle of a request.
        mem_wait = 5;
        push_data(32'h700, 1'b0, 32'h0, SIZE_WORD);
        run_traffic(40, 1'b1);
        check_eq("pre_rst_valid", 32'(o_mem_valid), 32'd1);
        i_if_req = 1'b1;
        i_d_req  = 1'b1;
        i_rst_n  = 1'b0;
        #1;
        check_eq("mid_rst_mem_valid", 32'(o_mem_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
        check_eq("mid_rst_if_ready", 32'(o_if_ready), 32'd0);
        check_eq("mid_rst_d_ready", 32'(o_d_ready), 32'd0);
        check_eq("mid_rst_mem_addr", o_mem_addr, 32'd0);
        check_eq("mid_rst_rvalid", 32'({o_if_rvalid, o_d_rvalid}), 32'd0);
        d_q.delete();
        f_q.delete();
        exp_mem_q.delete();
        exp_rsp_q.delete();
        mem_rsp_pending = 1'b0;
        mem_wait_cnt = 0;
        i_if_req = 1'b0;
        i_d_req = 1'b0;
        i_mem_ready = 1'b0;
        i_mem_rvalid = 1'b0;
        @(posedge i_clk);
        #3;
        check_eq("rst_hold_busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        mem_wait = 0;
        push_data(32'h800, 1'b0, 32'h0, SIZE_WORD);
        run_traffic(40, 1'b0);
        check_eq("post_rst_grant", 32'(first_grant), 32'd0);
        end_test("reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits.
REQ-003 Parameter MAX_D_STREAK, 4, max consecutive data grants while fetch waits; range 1..15.
REQ-004 i_clk  in  1  sole clock, all state on rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_if_req / o_if_ready / i_if_addr  in/out/in  1/1/AW  fetch request, read-only, word size.
REQ-007 i_if_flush  in  1  fetch redirect; kills any in-flight fetch.
REQ-008 o_if_rvalid / o_if_rdata  out  1/DW  fetch response.
REQ-009 i_d_req / o_d_ready / i_d_addr / i_d_we / i_d_wdata / i_d_size  in/out/in/in/in/in  1/1/AW/1/DW/2  data request; i_d_size is mem_size_e.
REQ-010 o_d_rvalid / o_d_rdata  out  1/DW  data response; store completion included.
REQ-011 o_mem_valid / i_mem_ready / o_mem_addr / o_mem_we / o_mem_wdata / o_mem_size  out/in/out/out/out/out  1/1/AW/1/DW/2  shared downstream port.
REQ-012 i_mem_rvalid / i_mem_rdata  in  1/DW  downstream response, one per accepted request, in order.
REQ-013 o_busy  out  1  high whenever state != IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, REQ and RESP, with at most one outstanding transaction.
REQ-015 In IDLE with any request, the winner SHALL be data unless fetch is requesting and streak == MAX_D_STREAK, in which case fetch wins.
REQ-016 In the IDLE cycle of selection, the winner's ready SHALL pulse for one cycle, its payload SHALL be registered, owner SHALL be latched, and the FSM SHALL go to REQ; the loser's ready SHALL stay low.
REQ-017 A fetch grant SHALL capture we=0 and size=WORD.
REQ-018 In REQ, o_mem_valid SHALL be 1 and payload SHALL be driven from registers, held stable until i_mem_ready=1; on ready the FSM SHALL go to RESP.
REQ-019 In RESP, i_mem_rvalid SHALL be routed combinationally to the owner's rvalid, and rdata to both rdata outputs; the FSM SHALL then return to IDLE.
REQ-020 The FSM SHALL ignore i_mem_rvalid outside RESP.
REQ-021 Minimum request-to-request spacing SHALL be 3 cycles (IDLE, REQ, RESP); no new grant occurs in the rvalid cycle.
REQ-022 streak (4 bits) SHALL increment on a data grant while i_if_req=1, saturating at MAX_D_STREAK, and SHALL clear on a fetch grant or any IDLE cycle with i_if_req=0.
REQ-023 i_if_flush in IDLE SHALL suppress a fetch grant in that cycle; data MAY still be granted.
REQ-024 i_if_flush while owner=fetch in REQ or RESP SHALL set a kill flag; o_mem_valid SHALL NOT be withdrawn; the matching rvalid SHALL be consumed with o_if_rvalid held 0; the kill SHALL clear on return to IDLE.
REQ-025 i_if_flush SHALL have no effect on a data-owned transaction.
REQ-026 Simultaneous i_mem_ready and i_mem_rvalid in REQ SHALL be treated as ready only; the downstream guarantees rvalid no earlier than the cycle after ready.

Reset
REQ-027 On i_rst_n=0, the block SHALL asynchronously go to state IDLE with streak=0, kill=0, owner=fetch and payload registers 0.
REQ-028 During reset, all ready, valid and rvalid outputs, and o_busy, SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon it; downstream is reset by the same i_rst_n.

Structure
REQ-030 mem_size_e {SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2} and mem_arb_state_e SHALL live in core_pkg.
REQ-031 The block SHALL be a single module with no sub-module; priority selection SHALL be inline combinational logic.

Verification
REQ-032 The bench SHALL cover: fetch only at addr 0x100, mem_ready after 2 cycles, rdata 0xDEADBEEF -> o_if_rvalid with 0xDEADBEEF, o_d_rvalid=0, o_busy for 4 cycles.
REQ-033 The bench SHALL cover: fetch and data asserted together, MAX_D_STREAK=4 -> grant order D,D,D,D,F,D.
REQ-034 The bench SHALL cover: a store at 0x2000 with wdata 0x12345678 and size HALF -> o_mem_we=1 and the payload is stable through 3 wait cycles of ready=0.
REQ-035 The bench SHALL cover: flush in the RESP cycle of a fetch -> rvalid is consumed, o_if_rvalid=0, and the next data request is granted normally.
REQ-036 The bench SHALL cover: reset asserted in REQ -> all outputs are 0 immediately, and the first request after release is granted in 1 cycle.
